fir_multichannel_mac: RTL
=========================

# fir_multichannel_mac

Time-multiplexed, parametrised multi-channel FIR filter for the accelerometer path. It is the successor of the single-axis x-only FIR hook. It captures one sample vector (all axes) per sample tick from the Nios PIO side. It then runs a single shared multiply-accumulate over every channel and tap, and returns saturated, scaled results through a valid/ready output. It sits between the accelerometer sample PIO and the filtered-output PIO.

## Interface
Parameters:
- CHANNELS, 3: number of axes filtered.
- TAPS, 8: taps per channel; need not be a power of two; minimum 2.
- DATA_W, 16: signed sample and result width.
- COEF_W, 16: signed coefficient width.
- OUT_SHIFT, 3: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk_clk  in  1  single clock.
- reset_reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample tick; the vector is accepted when in_valid && in_ready.
- in_ready  out  1  high only in IDLE.
- in_data  in  CHANNELS*DATA_W  packed samples; channel 0 in the LSBs.
- out_valid  out  1  result vector available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  CHANNELS*DATA_W  packed results; same packing as in_data.
- drop_cnt  out  16  count of in_valid cycles seen while in_ready is low; saturates at 0xFFFF.
- coef_wr  in  1  coefficient write strobe (FIR_COEF_LOAD_EN only).
- coef_addr  in  $clog2(TAPS)  tap index (FIR_COEF_LOAD_EN only).
- coef_data  in  COEF_W  signed coefficient (FIR_COEF_LOAD_EN only).

## Operation
- States: IDLE -> MAC on accept; MAC -> OUT after CHANNELS*TAPS products; OUT -> IDLE on out handshake.
- Each channel has a circular delay line of TAPS entries, with one shared write pointer that wraps from TAPS-1 to 0.
- On accept, the new sample becomes tap 0 (newest) for every channel and the oldest sample is overwritten.
- MAC issues one product per cycle, channel-major: ch0 taps 0..TAPS-1, then ch1, and so on. It computes acc += x[ch][k]*coef[k].
- ACC_W = DATA_W + COEF_W + $clog2(TAPS). Full-precision signed arithmetic is used with no intermediate truncation.
- At the last tap of each channel: result = acc >>> OUT_SHIFT, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The result is stored to that channel's out_data slice and acc is cleared.
- out_data is held stable while out_valid && !out_ready.
- in_valid while not IDLE: the sample is dropped, the delay lines are unchanged, and drop_cnt increments by 1 per cycle (saturating).

## Timing
- Reset values:
  - state IDLE, in_ready 1, out_valid 0, out_data 0, drop_cnt 0.
  - All delay-line entries 0, write pointer 0.
  - Coefficients set to defaults.
- Accept in cycle t: in_ready is low from t+1. Products are issued in cycles t+1..t+CHANNELS*TAPS. out_valid rises in cycle t+CHANNELS*TAPS+1.
- Output handshake in cycle u: out_valid is low and in_ready is high in u+1. A new accept is therefore possible no earlier than u+1.
- Minimum sample period is CHANNELS*TAPS+2 cycles.
- Reset asserted mid-MAC or in OUT: all of the reset values apply on the next edge. The partial accumulation is discarded.

## Configuration
- FIR_COEF_LOAD_EN defined:
  - coef_* ports exist.
  - A write is accepted only in IDLE: coef[coef_addr] <= coef_data, effective for the next accepted sample. Writes in other states are ignored.
  - coef_addr >= TAPS is ignored.
  - Reset restores the defaults.
- FIR_COEF_LOAD_EN undefined: no coef_* ports; the coefficients are constants equal to the defaults.
- Default coefficients are all 1. With OUT_SHIFT=$clog2(TAPS) this gives a moving average.

## Structure
- Package fir_mc_pkg holds:
  - the state enum (IDLE, MAC, OUT);
  - the default-coefficient function;
  - the saturation function;
  - the ACC_W computation function.
- One sub-module, fir_mc_delay_line: per-channel circular buffer with a shared pointer. It has a write port and a read port addressed by tap index, with registered pointer wrap.

## Test plan
Defaults are used throughout: CHANNELS=3, TAPS=8, DATA_W=16, COEF_W=16, OUT_SHIFT=3.
- Step response: after reset, feed constant (800, -800, 0). The first output is (100, -100, 0), increasing by 100 per sample. The 8th output onward is (800, -800, 0).
- Latency: accept in cycle t with out_ready=1. out_valid goes high in exactly t+25. in_ready is low in t+1..t+25 and high again in t+26.
- Back-pressure: hold out_ready=0 for 10 cycles in OUT while pulsing in_valid 4 times. out_data stays stable, drop_cnt reads 4, and the delay lines are unchanged (the next output matches the model).
- Saturation (FIR_COEF_LOAD_EN): load all coefficients as 16384 and feed 32767 eight times; output 32767. Feed -32768 eight times; output -32768.
- Coefficient load (FIR_COEF_LOAD_EN): coef[0]=8, others 0. Output equals input (1234, -5, 7). A write during MAC is ignored.
- Reset mid-MAC: assert reset in the 5th MAC cycle. out_valid stays 0 and drop_cnt is 0. A subsequent sample of 800 on ch0 yields 100, confirming the history was cleared.

Source files
------------

// File: rtl/fir_mc_pkg.sv
// Shared types and helpers for the multi-channel FIR MAC.
// Coefficient loading is enabled by defining FIR_COEF_LOAD_EN.
package fir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Accumulator must hold TAPS full-precision products without overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Flat unity taps; with OUT_SHIFT = log2(TAPS) the filter is a moving average.
  function automatic logic signed [63:0] default_coef();
    return 64'sd1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fir_mc_delay_line.sv
// Per-channel circular sample history sharing one write pointer.
// Read port addresses by tap index, where tap 0 is the newest sample.
module fir_mc_delay_line #(
  parameter int CHANNELS = 3,
  parameter int TAPS     = 8,
  parameter int DATA_W   = 16
) (
  input  logic                                         clk,
  input  logic                                         srst,
  input  logic                                         wr_en,
  input  logic [CHANNELS*DATA_W-1:0]                   wr_data,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rd_ch,
  input  logic [$clog2(TAPS)-1:0]                      rd_tap,
  output logic [DATA_W-1:0]                            rd_data
);

  localparam int PTR_W = $clog2(TAPS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TAPS - 1);
  localparam logic [PTR_W:0]   TAPS_EXT = (PTR_W + 1)'(TAPS);

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W:0]    idx_sum;
  logic [PTR_W-1:0]  rd_idx;
  logic [DATA_W-1:0] ch_rd [CHANNELS];

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= '0;
    end else if (wr_en) begin
      ptr_reg <= (ptr_reg == LAST_PTR) ? '0 : ptr_reg + 1'b1;
    end
  end

  // Newest entry sits just behind the pointer; one conditional subtract wraps non-power-of-two depths.
  always_comb begin
    idx_sum = {1'b0, ptr_reg} + (TAPS_EXT - 1'b1) - {1'b0, rd_tap};
    if (idx_sum >= TAPS_EXT) idx_sum = idx_sum - TAPS_EXT;
    rd_idx = idx_sum[PTR_W-1:0];
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_line
      logic [DATA_W-1:0] line_reg [TAPS];

      always_ff @(posedge clk) begin
        if (srst) begin
          for (int k = 0; k < TAPS; k++) line_reg[k] <= '0;
        end else if (wr_en) begin
          line_reg[ptr_reg] <= wr_data[gi*DATA_W +: DATA_W];
        end
      end

      assign ch_rd[gi] = line_reg[rd_idx];
    end
  endgenerate

  assign rd_data = ch_rd[rd_ch];

endmodule

// File: rtl/fir_multichannel_mac.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks channel-major over all taps.
// Define FIR_COEF_LOAD_EN to add the runtime coefficient write port.
module fir_multichannel_mac
  import fir_mc_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int TAPS      = 8,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 3
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic [15:0]                drop_cnt
`ifdef FIR_COEF_LOAD_EN
  ,
  input  logic                       coef_wr,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_data
`endif
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int TAP_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

  state_t state_reg;
  state_t state_next;

  logic [TAP_W-1:0]                tap_reg;
  logic [CH_W-1:0]                 ch_reg;
  logic signed [ACC_W-1:0]         acc_reg;
  logic [CHANNELS*DATA_W-1:0]      out_data_reg;
  logic [15:0]                     drop_cnt_reg;
  logic signed [COEF_W-1:0]        coef [TAPS];

  logic                            accept;
  logic                            last_tap;
  logic                            last_product;
  logic [DATA_W-1:0]               rd_sample;
  logic signed [DATA_W+COEF_W-1:0] product;
  logic signed [ACC_W-1:0]         acc_sum;
  logic signed [ACC_W-1:0]         acc_shifted;
  logic [DATA_W-1:0]               result;

  assign accept       = in_valid && (state_reg == IDLE);
  assign last_tap     = (tap_reg == LAST_TAP);
  assign last_product = (state_reg == MAC) && last_tap && (ch_reg == LAST_CH);

  fir_mc_delay_line #(
    .CHANNELS (CHANNELS),
    .TAPS     (TAPS),
    .DATA_W   (DATA_W)
  ) u_delay_line (
    .clk     (clk_clk),
    .srst    (reset_reset),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_ch   (ch_reg),
    .rd_tap  (tap_reg),
    .rd_data (rd_sample)
  );

`ifdef FIR_COEF_LOAD_EN
  // Writes only land while idle so a filter pass always sees one coefficient set.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= COEF_W'(default_coef());
    end else if (coef_wr && (state_reg == IDLE) && (32'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end
`else
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
      assign coef[gi] = COEF_W'(default_coef());
    end
  endgenerate
`endif

  assign product     = $signed(rd_sample) * coef[tap_reg];
  assign acc_sum     = acc_reg + ACC_W'(product);
  assign acc_shifted = acc_sum >>> OUT_SHIFT;
  assign result      = DATA_W'(saturate(64'(acc_shifted), DATA_W));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (last_product) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == OUT);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tap_reg      <= '0;
      ch_reg       <= '0;
      acc_reg      <= '0;
      out_data_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (accept) begin
        tap_reg <= '0;
        ch_reg  <= '0;
        acc_reg <= '0;
      end else if (state_reg == MAC) begin
        if (last_tap) begin
          tap_reg <= '0;
          ch_reg  <= ch_reg + 1'b1;
          acc_reg <= '0;
          out_data_reg[ch_reg*DATA_W +: DATA_W] <= result;
        end else begin
          tap_reg <= tap_reg + 1'b1;
          acc_reg <= acc_sum;
        end
      end
      if (in_valid && (state_reg != IDLE) && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign out_data = out_data_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
